// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // One spare bit so the counter can hold WIDTH/STEP itself.
    function automatic int mdu_cnt_width(input int width, input int step);
        return $clog2(width / step) + 1;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply keeps {hi,lo} = {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b} : '0);
        shifted = {hi_in, lo_in[WIDTH-1]};
        // The remainder stays below the divisor, so a successful trial fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - b;
        hi_out  = sum[WIDTH:1];
        lo_out  = {sum[0], lo_in[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, b}) begin
                hi_out = diff;
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shifted[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, with MTHI/MTLO writes.
//
// state | meaning
// IDLE  | waiting for start; HI/LO direct writes accepted
// RUN   | STEP iterations per edge on magnitudes held in acc_hi/acc_lo
// FIX   | sign correction, HI/LO update, done pulse
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = mdu_cnt_width(WIDTH, STEP);

    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_step
        $error("mult_div_unit: STEP must be 1, 2 or 4 and must divide WIDTH");
    end

    mdu_state_e state, next_state;

    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic             neg_res;
    logic             neg_rem;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_q;

    logic             start_signed;
    logic             start_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH-1:0] chain_hi [STEP+1];
    logic [WIDTH-1:0] chain_lo [STEP+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == CNT_W'(N - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_signed = 1'b0;
        start_div    = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT:  start_signed = 1'b1;
            MDU_MULTU: start_signed = 1'b0;
            MDU_DIV:   begin start_signed = 1'b1; start_div = 1'b1; end
            MDU_DIVU:  start_div = 1'b1;
            default:   start_div = 1'b0;
        endcase
        a_neg = start_signed & operand_a[WIDTH-1];
        b_neg = start_signed & operand_b[WIDTH-1];
        abs_a = a_neg ? -operand_a : operand_a;
        abs_b = b_neg ? -operand_b : operand_b;
    end

    assign chain_hi[0] = acc_hi;
    assign chain_lo[0] = acc_lo;

    for (genvar i = 0; i < STEP; i++) begin : g_chain
        mdu_step #(.WIDTH(WIDTH)) u_step (
            .is_div (div_q),
            .hi_in  (chain_hi[i]),
            .lo_in  (chain_lo[i]),
            .b      (b_q),
            .hi_out (chain_hi[i+1]),
            .lo_out (chain_lo[i+1])
        );
    end

    always_comb begin
        prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            div_q    <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw    <= '0;
            b_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        div_q    <= start_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        b_zero_q <= start_div && (operand_b == '0);
                        a_raw    <= operand_a;
                        b_q      <= abs_b;
                        acc_hi   <= '0;
                        acc_lo   <= abs_a;
                    end else begin
                        if (hi_write) hi_q <= write_data;
                        if (lo_write) lo_q <= write_data;
                    end
                end
                RUN: begin
                    acc_hi <= chain_hi[STEP];
                    acc_lo <= chain_lo[STEP];
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (!div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (b_zero_q) begin
                        hi_q  <= a_raw;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, handshake corner cases,
// and random operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, hi_write, lo_write;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, write_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start4, hi_write4, lo_write4;
    logic [1:0]  op4;
    logic [31:0] a4, b4, wd4;
    logic        busy4, done4, dbz4;
    logic [31:0] hi4, lo4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .STEP(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4),
        .operand_a(a4), .operand_b(b4),
        .hi_write(hi_write4), .lo_write(lo_write4), .write_data(wd4),
        .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          exp_dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        int          lat;
        int          bcnt;
        bit          glitch;
        bit          busy_end;
        bit          after;
    } res_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl, output bit rd);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        rd = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = ua * ub;      rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (b == 0) begin
                    rh = a; rl = 32'hFFFF_FFFF; rd = 1'b1;
                end else if (o == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    p  = 64'(sq); rl = p[31:0];
                    p  = 64'(sr); rh = p[31:0];
                end else begin
                    p = ua / ub; rl = p[31:0];
                    p = ua % ub; rh = p[31:0];
                end
            end
        endcase
    endfunction

    // Issue one operation on the STEP=1 instance and follow it to its done pulse.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit lo_wr, output res_t r);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        if (lo_wr) begin lo_write = 1'b1; write_data = 32'hDEAD_BEEF; end
        tick();
        start = 1'b0; lo_write = 1'b0;
        r.lat = 0; r.bcnt = busy ? 1 : 0; r.glitch = done | div_by_zero;
        while (1) begin
            tick();
            r.lat++;
            if (done) break;
            if (busy) r.bcnt++;
            if (div_by_zero) r.glitch = 1'b1;
            if (r.lat >= 200) break;
        end
        r.hi = hi; r.lo = lo; r.dbz = div_by_zero; r.busy_end = busy;
        tick();
        r.after = done | div_by_zero;
    endtask

    task automatic check_res(input string name, input res_t r, input logic [31:0] eh,
                             input logic [31:0] el, input bit ed);
        check({name, ".hi"}, 64'(r.hi), 64'(eh));
        check({name, ".lo"}, 64'(r.lo), 64'(el));
        check({name, ".dbz"}, 64'(r.dbz), 64'(ed));
        check({name, ".latency"}, 64'(r.lat), 64'd33);
        check({name, ".busy_cycles"}, 64'(r.bcnt), 64'd33);
        check({name, ".early_pulse"}, 64'(r.glitch), 64'd0);
        check({name, ".busy_at_done"}, 64'(r.busy_end), 64'd0);
        check({name, ".pulse_after"}, 64'(r.after), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        res_t        r;
        logic [31:0] eh, el;
        bit          ed;
        int          lat4, ndone, seen;
        logic [31:0] h_at_done, l_at_done;

        reset = 1'b0; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        op = '0; operand_a = '0; operand_b = '0; write_data = '0;
        start4 = 1'b0; hi_write4 = 1'b0; lo_write4 = 1'b0; op4 = '0; a4 = '0; b4 = '0; wd4 = '0;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd3, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
        vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[6] = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{2'd1, 32'd0,         32'h1234,      32'd0,         32'd0,         1'b0};

        repeat (2) tick();
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r);
            check_res($sformatf("vec%0d", i), r, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
        end

        // STEP=4 instance: same product, N+1 = 9 edges.
        op4 = 2'd1; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; start4 = 1'b1;
        tick();
        start4 = 1'b0; lat4 = 0;
        while (lat4 < 100) begin
            tick();
            lat4++;
            if (done4) break;
        end
        check("step4.latency", 64'(lat4), 64'd9);
        check("step4.hi", 64'(hi4), 64'hFFFF_FFFE);
        check("step4.lo", 64'(lo4), 64'h0000_0001);

        // start and hi_write while busy are both ignored.
        op = 2'd3; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op = 2'd1; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
        hi_write = 1'b1; write_data = 32'h55;
        tick();
        start = 1'b0; hi_write = 1'b0;
        ndone = 0; h_at_done = '0; l_at_done = '0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done) begin ndone++; h_at_done = hi; l_at_done = lo; end
        end
        check("busy_ignore.done_count", 64'(ndone), 64'd1);
        check("busy_ignore.hi", 64'(h_at_done), 64'd6);
        check("busy_ignore.lo", 64'(l_at_done), 64'd142);
        check("busy_ignore.busy_after", 64'(busy), 64'd0);

        // Direct writes in IDLE.
        hi_write = 1'b1; write_data = 32'h55;
        tick();
        hi_write = 1'b0;
        check("mthi.hi", 64'(hi), 64'h55);
        check("mthi.lo_kept", 64'(lo), 64'd142);
        hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hA5A5_5A5A;
        tick();
        hi_write = 1'b0; lo_write = 1'b0;
        check("mthilo.hi", 64'(hi), 64'hA5A5_5A5A);
        check("mthilo.lo", 64'(lo), 64'hA5A5_5A5A);

        // start wins over a simultaneous lo_write.
        run_op(2'd1, 32'd6, 32'd7, 1'b1, r);
        check_res("start_lo_write", r, 32'd0, 32'd42, 1'b0);

        // Asynchronous reset in the middle of a divide.
        op = 2'd3; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b0;
        #1;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.hi", 64'(hi), 64'd0);
        check("midreset.lo", 64'(lo), 64'd0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) seen = 1;
        end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) seen = 1;
        end
        check("midreset.no_done", 64'(seen), 64'd0);
        run_op(2'd1, 32'd2, 32'd3, 1'b0, r);
        check_res("after_reset", r, 32'd0, 32'd6, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       begin rb = $urandom; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            ref_model(ro, ra, rb, eh, el, ed);
            run_op(ro, ra, rb, 1'b0, r);
            check($sformatf("rand%0d.hi op=%0d a=%h b=%h", i, ro, ra, rb), 64'(r.hi), 64'(eh));
            check($sformatf("rand%0d.lo op=%0d a=%h b=%h", i, ro, ra, rb), 64'(r.lo), 64'(el));
            check($sformatf("rand%0d.dbz", i), 64'(r.dbz), 64'(ed));
            check($sformatf("rand%0d.latency", i), 64'(r.lat), 64'd33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
